delay_line_ctrl: RTL and testbench
==================================

Name: delay_line_ctrl

Overview:
- Sequences the dual-port audio SRAM (1RW port 0, 1R port 1) as a circular delay buffer for the pedal's delay/echo effect.
- Each accepted input sample triggers two SRAM accesses:
  - a read of the sample from delay_len samples ago on port 1;
  - a write of the new sample on port 0.
- Zero-fills the SRAM after reset, because the SRAM has no reset of its own.
- Sits between the audio sample pipeline and the SRAM macro, and drives both SRAM clocks from clk.

Parameters:
- DATA_WIDTH, 16, sample width. Matches the SRAM word.
- ADDR_WIDTH, 14, SRAM address width. Buffer depth is DEPTH = 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock. Also drives SRAM clk0/clk1.
- rst_n  in  1  asynchronous active-low reset.
- sample_in  in  DATA_WIDTH  signed input sample.
- sample_valid  in  1  one-cycle strobe, sample_in valid.
- ready  out  1  controller idle; sample_valid is accepted only when ready=1.
- delay_len  in  ADDR_WIDTH  delay in samples, 0..DEPTH-1. Sampled on accept.
- clear_req  in  1  pulse; re-zeroes the buffer. Honoured in IDLE only.
- sample_out  out  DATA_WIDTH  delayed sample.
- out_valid  out  1  one-cycle strobe, sample_out updated.
- overrun  out  1  sticky; a sample_valid arrived while ready=0.
- clearing  out  1  high while the CLEAR sweep runs.
- csb0, web0  out  1 each  SRAM port 0 chip select and write enable, both active low.
- addr0  out  ADDR_WIDTH  SRAM port 0 address.
- din0  out  DATA_WIDTH  SRAM port 0 write data.
- csb1  out  1  SRAM port 1 chip select, active low.
- addr1  out  ADDR_WIDTH  SRAM port 1 address.
- dout1  in  DATA_WIDTH  SRAM port 1 read data.

Behaviour:
- Register timing
  - All SRAM-facing outputs are registered.
  - The SRAM samples its inputs on the posedge and updates dout1 at the following negedge.
  - The controller therefore captures dout1 on the posedge after the SRAM samples the request.
- Reset state
  - csb0=1, web0=1, csb1=1, addr0=0, addr1=0, din0=0.
  - sample_out=0, out_valid=0, overrun=0, ready=0, clearing=1.
  - wr_ptr=0, state=CLEAR.
  - Reset asserted mid-operation aborts any access and restarts the CLEAR sweep.
- CLEAR
  - One write per cycle: csb0=0, web0=0, din0=0, addr0 = 0..DEPTH-1.
  - After writing DEPTH-1, deassert csb0/web0, drop clearing, go to IDLE.
  - Takes DEPTH+1 cycles.
- IDLE
  - ready=1.
  - clear_req has priority over sample_valid in the same cycle. clear_req goes to CLEAR; the sample is dropped and overrun is set.
  - On sample_valid (edge E0), latch sample_in and delay_len, then go to RD.
    - If delay_len != 0: register csb1=0, addr1=(wr_ptr - delay_len) mod DEPTH.
    - If delay_len == 0: leave csb1=1 (bypass).
- RD (edge E1): the SRAM samples the read. Go to CAP.
- CAP (edge E2)
  - sample_out <= dout1, or the latched sample_in when delay_len==0. out_valid=1 for one cycle.
  - csb1=1.
  - Register the write: csb0=0, web0=0, addr0=wr_ptr, din0=write data. Go to WR.
- WR (edge E3)
  - csb0=1, web0=1.
  - wr_ptr <= wr_ptr+1, wrapping from DEPTH-1 to 0.
  - Go to IDLE. ready returns after E3.
- Throughput and latency
  - Latency from sample_valid to out_valid is 2 cycles.
  - Minimum spacing between accepted samples is 4 cycles.
- overrun
  - Set on sample_valid while ready=0, including during CLEAR. That sample is dropped.
  - Cleared only by reset.
- delay_len changes take effect on the next accepted sample. There is no partial-cycle effect.
- Port 0 is never read, and dout0 is ignored.
- Port 0 and port 1 never access the same address in the same cycle. The read in RD always precedes the write in WR.

Optional Feature:
- Macro: DELAY_LINE_FEEDBACK_EN.
- Defined:
  - Adds input port fb_gain [7:0], unsigned Q0.8.
  - Write data = saturate(sample_in + ((delayed * fb_gain) >>> 8)), computed from dout1 in CAP. Saturation clamps to the signed DATA_WIDTH range.
  - When delay_len==0, feedback is forced off and the write data is sample_in.
- Undefined: no fb_gain port; write data = sample_in. Timing is identical in both builds.

Decomposition:
- Package delay_line_pkg:
  - state enum {CLEAR, IDLE, RD, CAP, WR};
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - FB_GAIN_W=8.
- Sub-module delay_line_fb_mac: combinational signed multiply, arithmetic shift and saturating add. Instantiated only under DELAY_LINE_FEEDBACK_EN.

Test Plan:
- Reset, then wait: clearing high for DEPTH+1 cycles; every SRAM word written 0; ready rises; csb1 stays 1 throughout.
- delay_len=3, feed samples 1,2,3,4,5: sample_out sequence is 0,0,0,1,2; out_valid 2 cycles after each sample_valid.
- delay_len=0, sample_in=0x1234: sample_out=0x1234; csb1 never asserted; address wr_ptr is written with 0x1234.
- wr_ptr wrap, DEPTH=16 in bench, delay_len=15, 20 samples: read addresses wrap correctly (e.g. wr_ptr=2 reads addr 3); output equals the sample from 15 samples earlier.
- sample_valid in RD, and clear_req coincident with sample_valid in IDLE: overrun=1 and stays set; sample dropped; the CLEAR sweep runs in the second case.
- FEEDBACK_EN with fb_gain=0x80, delay_len=1, input 0x4000 then 0: second write = 0x2000. With 0x7000 stored and input 0x7000, write saturates to 0x7FFF.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared types and defaults for the delay-line SRAM sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package delay_line_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 14;

  // Feedback gain is unsigned Q0.8.
  localparam int FB_GAIN_W = 8;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RD,
    CAP,
    WR
  } state_t;

endpackage

// File: rtl/delay_line_fb_mac.sv
// Feedback mixer: result = saturate(sample + ((delayed * gain) >>> 8)).
// Latency: combinational, zero cycles.
// Backpressure: none; the result is valid whenever the inputs are.
//
// Ports:
//   sample  - new input sample (signed)
//   delayed - sample read back from the delay buffer (signed)
//   gain    - unsigned Q0.8 feedback gain
//   result  - mixed sample, clamped to the signed DATA_WIDTH range
module delay_line_fb_mac
  import delay_line_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic signed [DATA_WIDTH-1:0] delayed,
  input  logic        [FB_GAIN_W-1:0]  gain,
  output logic signed [DATA_WIDTH-1:0] result
);

  // Product needs DATA_WIDTH + 9 bits (gain is zero-extended to stay positive);
  // the sum needs one more bit so it can never wrap before the clamp.
  localparam int PW = DATA_WIDTH + FB_GAIN_W + 1;
  localparam int SW = PW + 1;

  logic signed [PW-1:0]         gain_s;
  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         scaled;
  logic signed [SW-1:0]         sum;
  logic        [SW-DATA_WIDTH:0] top_bits;
  logic                         in_range;

  always_comb begin
    gain_s   = PW'($signed({1'b0, gain}));
    prod     = PW'(delayed) * gain_s;
    scaled   = prod >>> FB_GAIN_W;
    sum      = SW'(sample) + SW'(scaled);
    // The sum fits when every bit from the result's sign bit upward agrees.
    top_bits = sum[SW-1:DATA_WIDTH-1];
    in_range = (&top_bits) | ~(|top_bits);
    if (in_range) begin
      result = sum[DATA_WIDTH-1:0];
    end else if (sum[SW-1]) begin
      result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// Circular delay-buffer sequencer for a 1RW/1R audio SRAM (read old sample, write new one).
// Latency: out_valid 2 cycles after an accepted sample_valid; one sample per 4 cycles max.
// Backpressure: ready=1 only in IDLE; a sample_valid without ready is dropped and sets sticky overrun.
//
// Ports:
//   clk, rst_n                 - clock (also the SRAM clock) and async active-low reset
//   sample_in, sample_valid    - input sample strobe, accepted only while ready=1
//   delay_len                  - delay in samples, captured when a sample is accepted
//   clear_req                  - re-zero the buffer (honoured in IDLE only)
//   sample_out, out_valid      - delayed sample and its one-cycle strobe
//   overrun, clearing          - sticky drop flag, zero-fill sweep in progress
//   csb0/web0/addr0/din0       - SRAM port 0 (write only), active-low controls
//   csb1/addr1/dout1           - SRAM port 1 (read only), active-low select
//   fb_gain                    - feedback gain, present only with DELAY_LINE_FEEDBACK_EN
//
// Build option: define DELAY_LINE_FEEDBACK_EN to mix the delayed sample back into the write data.
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  ready,
  input  logic [ADDR_WIDTH-1:0] delay_len,
`ifdef DELAY_LINE_FEEDBACK_EN
  input  logic [FB_GAIN_W-1:0]  fb_gain,
`endif
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  out_valid,
  output logic                  overrun,
  output logic                  clearing,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  state_t                  state, state_d;
  // One extra bit so the sweep can tell "address DEPTH-1 issued" from "not started".
  logic [ADDR_WIDTH:0]     clr_cnt, clr_cnt_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_d;
  logic [DATA_WIDTH-1:0]   samp_q, samp_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;

  logic                    csb0_d, web0_d, csb1_d;
  logic [ADDR_WIDTH-1:0]   addr0_d, addr1_d;
  logic [DATA_WIDTH-1:0]   din0_d;
  logic [DATA_WIDTH-1:0]   sample_out_d;
  logic                    out_valid_d;
  logic                    overrun_d;
  logic [DATA_WIDTH-1:0]   wdata;

  assign ready    = (state == IDLE);
  assign clearing = (state == CLEAR);

`ifdef DELAY_LINE_FEEDBACK_EN
  // A zero delay reads nothing, so dout1 is stale then; force the feedback off.
  logic [FB_GAIN_W-1:0] gain_eff;
  assign gain_eff = (len_q == '0) ? '0 : fb_gain;

  delay_line_fb_mac #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fb_mac (
    .sample  (samp_q),
    .delayed (dout1),
    .gain    (gain_eff),
    .result  (wdata)
  );
`else
  assign wdata = samp_q;
`endif

  always_comb begin
    state_d      = state;
    clr_cnt_d    = clr_cnt;
    wr_ptr_d     = wr_ptr;
    samp_d       = samp_q;
    len_d        = len_q;
    csb0_d       = 1'b1;
    web0_d       = 1'b1;
    addr0_d      = addr0;
    din0_d       = din0;
    csb1_d       = 1'b1;
    addr1_d      = addr1;
    sample_out_d = sample_out;
    out_valid_d  = 1'b0;
    // Any strobe outside IDLE is lost; a strobe that loses to clear_req is lost too.
    overrun_d    = overrun | (sample_valid & ~ready) |
                   ((state == IDLE) & clear_req & sample_valid);

    case (state)
      CLEAR: begin
        if (clr_cnt[ADDR_WIDTH]) begin
          state_d = IDLE;
        end else begin
          csb0_d    = 1'b0;
          web0_d    = 1'b0;
          addr0_d   = clr_cnt[ADDR_WIDTH-1:0];
          din0_d    = '0;
          clr_cnt_d = clr_cnt + 1'b1;
        end
      end

      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (sample_valid) begin
          samp_d  = sample_in;
          len_d   = delay_len;
          state_d = RD;
          // A zero delay is served from the latched sample; no SRAM read.
          if (delay_len != '0) begin
            csb1_d  = 1'b0;
            addr1_d = wr_ptr - delay_len;
          end
        end
      end

      RD: begin
        // Keep the read request up until the data is captured.
        csb1_d  = csb1;
        state_d = CAP;
      end

      CAP: begin
        sample_out_d = (len_q == '0) ? samp_q : dout1;
        out_valid_d  = 1'b1;
        csb0_d       = 1'b0;
        web0_d       = 1'b0;
        addr0_d      = wr_ptr;
        din0_d       = wdata;
        state_d      = WR;
      end

      WR: begin
        // Natural wrap of the pointer width gives the modulo-DEPTH behaviour.
        wr_ptr_d = wr_ptr + 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      wr_ptr     <= '0;
      samp_q     <= '0;
      len_q      <= '0;
      csb0       <= 1'b1;
      web0       <= 1'b1;
      addr0      <= '0;
      din0       <= '0;
      csb1       <= 1'b1;
      addr1      <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      clr_cnt    <= clr_cnt_d;
      wr_ptr     <= wr_ptr_d;
      samp_q     <= samp_d;
      len_q      <= len_d;
      csb0       <= csb0_d;
      web0       <= web0_d;
      addr0      <= addr0_d;
      din0       <= din0_d;
      csb1       <= csb1_d;
      addr1      <= addr1_d;
      sample_out <= sample_out_d;
      out_valid  <= out_valid_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl with a 16-word SRAM model.
// Latency: n/a.
// Backpressure: stimulus waits on ready, except where drops are provoked on purpose.
module tb_delay_line_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          ready;
  logic [AW-1:0] delay_len;
  logic          clear_req;
  logic [DW-1:0] sample_out;
  logic          out_valid;
  logic          overrun;
  logic          clearing;
  logic          csb0, web0, csb1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout1;
`ifdef DELAY_LINE_FEEDBACK_EN
  logic [7:0]    fb_gain;
`endif

  always #5 clk = ~clk;

  delay_line_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .ready        (ready),
    .delay_len    (delay_len),
`ifdef DELAY_LINE_FEEDBACK_EN
    .fb_gain      (fb_gain),
`endif
    .clear_req    (clear_req),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .overrun      (overrun),
    .clearing     (clearing),
    .csb0         (csb0),
    .web0         (web0),
    .addr0        (addr0),
    .din0         (din0),
    .csb1         (csb1),
    .addr1        (addr1),
    .dout1        (dout1)
  );

  // SRAM model: inputs sampled on posedge, read data appears at the next negedge.
  // Contents are scrambled while reset is held, since the real macro has no reset.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom);
      rd_q <= DW'($urandom);
    end else begin
      if (!csb0 && !web0) mem[addr0] <= din0;
      if (!csb1) rd_q <= mem[addr1];
    end
  end
  always @(negedge clk) dout1 <= rd_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the buffer as an array of what has been stored, addressed by sample count.
  logic [DW-1:0] ref_buf [DEPTH];
  int            ref_wp = 0;
  logic [DW-1:0] q_out_dat[$];
  int            q_out_cyc[$];
  int            q_wr_addr[$];
  logic [DW-1:0] q_wr_dat[$];
  int            q_rd_addr[$];

  function automatic logic [DW-1:0] sat_add(input int a, input int b);
    int v;
    v = a + b;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return DW'(v);
  endfunction

  // Monitor: sampled on the negedge, well away from the active edge.
  logic csb1_prev     = 1'b1;
  logic clearing_prev = 1'b0;
  int   clr_idx       = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q_out_dat.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          check("sample_out", sample_out, q_out_dat.pop_front());
          check("out_latency_cycle", cyc, q_out_cyc.pop_front());
        end
      end
      if (!csb0 && !web0) begin
        if (clearing) begin
          check("clear_addr0", addr0, clr_idx);
          check("clear_din0", din0, 0);
          clr_idx++;
        end else if (q_wr_addr.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          check("write_addr0", addr0, q_wr_addr.pop_front());
          check("write_din0", din0, q_wr_dat.pop_front());
        end
      end
      if (!csb1 && csb1_prev) begin
        if (clearing || q_rd_addr.size() == 0) check("unexpected_read", 1, 0);
        else check("read_addr1", addr1, q_rd_addr.pop_front());
      end
      if (clearing_prev && !clearing) check("clear_word_count", clr_idx, DEPTH);
      if (!clearing) clr_idx = 0;
      csb1_prev     = csb1;
      clearing_prev = clearing;
    end
  end

  // All main-flow code runs in the phase #1 after a posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      tick();
      n++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [DW-1:0] s, input logic [AW-1:0] len);
    int            idx;
    logic [DW-1:0] d, wv;
    wait_ready(50);
    idx = ((ref_wp - int'(len)) % DEPTH + DEPTH) % DEPTH;
    d   = (len == 0) ? s : ref_buf[idx];
    wv  = s;
`ifdef DELAY_LINE_FEEDBACK_EN
    if (len != 0) wv = sat_add(int'($signed(s)), (int'($signed(d)) * int'(fb_gain)) >>> 8);
`endif
    q_out_dat.push_back(d);
    q_out_cyc.push_back(cyc + 3);  // accept edge is cyc+1, out_valid shows 2 cycles later
    q_wr_addr.push_back(ref_wp);
    q_wr_dat.push_back(wv);
    if (len != 0) q_rd_addr.push_back(idx);
    ref_buf[ref_wp] = wv;
    ref_wp = (ref_wp + 1) % DEPTH;
    sample_in    = s;
    delay_len    = len;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    // Scramble inputs after accept: the DUT must use its latched copies.
    sample_in    = DW'($urandom);
    delay_len    = AW'($urandom);
  endtask

  task automatic wait_clear_done();
    int n = 0;
    do begin
      tick();
      n++;
    end while (clearing && n < 100);
    check("clear_cycles", n, DEPTH + 1);
    check("ready_after_clear", ready, 1);
    for (int i = 0; i < DEPTH; i++) check("mem_zero", mem[i], 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    delay_len    = '0;
    clear_req    = 1'b0;
`ifdef DELAY_LINE_FEEDBACK_EN
    fb_gain      = 8'h00;
`endif
    for (int i = 0; i < DEPTH; i++) ref_buf[i] = '0;

    repeat (3) tick();
    check("rst_csb0", csb0, 1);
    check("rst_web0", web0, 1);
    check("rst_csb1", csb1, 1);
    check("rst_addr0", addr0, 0);
    check("rst_addr1", addr1, 0);
    check("rst_din0", din0, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ready", ready, 0);
    check("rst_clearing", clearing, 1);

    @(negedge clk);
    rst_n = 1'b1;
    wait_clear_done();

    // Short delay from a zeroed buffer.
    for (int i = 1; i <= 5; i++) send(DW'(i), 4'd3);

    // Zero delay bypass.
    send(16'h1234, 4'd0);

    // Longest delay, enough samples to wrap the write pointer.
    for (int i = 0; i < 20; i++) send(DW'($urandom), 4'd15);

    // Random data, delays and gaps.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(DW'($urandom), AW'($urandom));
    end

    check("overrun_before_drop", overrun, 0);

    // Strobe while the controller is busy reading: dropped, overrun set.
    send(16'h0aaa, 4'd2);
    sample_in    = 16'h0bbb;
    delay_len    = 4'd1;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("overrun_busy_drop", overrun, 1);

    // clear_req beats a coincident strobe; buffer re-zeroed.
    wait_ready(50);
    sample_in    = 16'h0ccc;
    sample_valid = 1'b1;
    clear_req    = 1'b1;
    tick();
    sample_valid = 1'b0;
    clear_req    = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_buf[i] = '0;
    check("clearing_after_req", clearing, 1);
    wait_clear_done();
    check("overrun_sticky", overrun, 1);
    for (int i = 0; i < 4; i++) send(DW'($urandom), 4'd5);

`ifdef DELAY_LINE_FEEDBACK_EN
    // Half-gain echo of a stored 0x4000, then saturation on 0x7000 + 0x7000/2.
    repeat (4) tick();
    fb_gain = 8'h80;
    send(16'h4000, 4'd1);
    send(16'h0000, 4'd1);
    repeat (4) tick();
    fb_gain = 8'h00;
    send(16'h7000, 4'd1);
    repeat (4) tick();
    fb_gain = 8'h80;
    send(16'h7000, 4'd1);
    send(16'h8000, 4'd0);
    repeat (4) tick();
    fb_gain = 8'h00;
`endif

    // Drain the scoreboard with a bounded wait.
    begin
      int n = 0;
      while ((q_out_dat.size() != 0 || q_wr_addr.size() != 0) && n < 100) begin
        tick();
        n++;
      end
      repeat (3) tick();
    end
    check("pending_outputs", q_out_dat.size(), 0);
    check("pending_writes", q_wr_addr.size(), 0);
    check("pending_reads", q_rd_addr.size(), 0);
    check("overrun_final", overrun, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
